// File: rtl/iob_except_ring_pkg.sv
// Shared types and defaults for the instruction-order-buffer exception ring.
`ifndef EXCEPT_WIDTH
`define EXCEPT_WIDTH 16
`endif

package iob_except_ring_pkg;

  localparam int unsigned EXCEPT_W   = `EXCEPT_WIDTH;
  localparam int unsigned ROW_W_DEF  = 6;
  localparam int unsigned BANK_W_DEF = 4;

  typedef logic [EXCEPT_W-1:0] except_t;

  typedef struct packed {
    logic [ROW_W_DEF-1:0]  row;
    logic [BANK_W_DEF-1:0] bank;
  } slot_addr_t;

  // Packed write address is {row, bank}, bank in the low bits.
  function automatic slot_addr_t split_addr(input logic [ROW_W_DEF+BANK_W_DEF-1:0] addr);
    slot_addr_t s;
    s.row  = addr[BANK_W_DEF +: ROW_W_DEF];
    s.bank = addr[0 +: BANK_W_DEF];
    return s;
  endfunction

endpackage

// File: rtl/iob_except_ring_bank.sv
// One bank column of the exception ring: record storage, valid bits and registered-row read.
module iob_except_ring_bank
  import iob_except_ring_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = EXCEPT_W,
  parameter int unsigned ROWS       = 48,
  parameter int unsigned ROW_W      = ROW_W_DEF,
  parameter int unsigned WPORTS     = 9
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WPORTS-1:0]            wr_en,
  input  logic [WPORTS*ROW_W-1:0]      wr_row,
  input  logic [WPORTS*DATA_WIDTH-1:0] wr_data,
  input  logic                         init_en,
  input  logic [ROW_W-1:0]             init_row,
  input  logic [DATA_WIDTH-1:0]        init_data,
  input  logic                         rd_step,
  input  logic [ROW_W-1:0]             rd_addr,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         rd_vld
);

  logic [DATA_WIDTH-1:0] mem [ROWS];
  logic [ROWS-1:0]       vld;
  logic [ROW_W-1:0]      rd_row;

  // Ascending port order makes the highest port win; init is applied last so it wins.
  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < WPORTS; p++) begin
      if (wr_en[p]) mem[wr_row[p*ROW_W +: ROW_W]] <= wr_data[p*DATA_WIDTH +: DATA_WIDTH];
    end
    if (init_en) mem[init_row] <= init_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld    <= '0;
      rd_row <= '0;
    end else begin
      for (int unsigned p = 0; p < WPORTS; p++) begin
        if (wr_en[p]) vld[wr_row[p*ROW_W +: ROW_W]] <= 1'b1;
      end
      if (init_en) vld[init_row] <= 1'b0;
      if (rd_step) rd_row <= rd_addr;
    end
  end

  always_comb begin
    rd_vld  = (32'(rd_row) < ROWS) && vld[rd_row];
    rd_data = rd_vld ? mem[rd_row] : '0;
  end

endmodule

// File: rtl/iob_except_ring.sv
// Exception-record ring: bank decode of writeback ports, sticky address error, first-exception encoder.
module iob_except_ring
  import iob_except_ring_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = EXCEPT_W,
  parameter int unsigned ROWS       = 48,
  parameter int unsigned ROW_W      = ROW_W_DEF,
  parameter int unsigned BANKS      = 10,
  parameter int unsigned BANK_W     = BANK_W_DEF,
  parameter int unsigned WPORTS     = 9
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WPORTS-1:0]             wr_en,
  input  logic [WPORTS*(ROW_W+BANK_W)-1:0] wr_addr,
  input  logic [WPORTS*DATA_WIDTH-1:0]  wr_data,
  input  logic                          init_en,
  input  logic [ROW_W-1:0]              init_addr,
  input  logic [BANKS*DATA_WIDTH-1:0]   init_data,
  input  logic                          rd_step,
  input  logic [ROW_W-1:0]              rd_addr,
  output logic [BANKS*DATA_WIDTH-1:0]   rd_data,
  output logic [BANKS-1:0]              rd_vld,
  output logic                          rd_any,
  output logic [BANK_W-1:0]             rd_first,
  output logic                          err_addr
);

  localparam int unsigned AW = ROW_W + BANK_W;

  logic [WPORTS-1:0]       bank_wr [BANKS];
  logic [WPORTS*ROW_W-1:0] wr_row;
  logic                    wr_bad;
  logic                    init_ok;
  logic                    rd_ok;

  always_comb begin : decode
    logic [ROW_W-1:0]  row;
    logic [BANK_W-1:0] bank;
    wr_row = '0;
    wr_bad = 1'b0;
    for (int unsigned k = 0; k < BANKS; k++) bank_wr[k] = '0;
    for (int unsigned p = 0; p < WPORTS; p++) begin
      row  = wr_addr[p*AW+BANK_W +: ROW_W];
      bank = wr_addr[p*AW +: BANK_W];
      wr_row[p*ROW_W +: ROW_W] = row;
      if (wr_en[p]) begin
        if ((32'(row) < ROWS) && (32'(bank) < BANKS)) begin
          for (int unsigned k = 0; k < BANKS; k++) begin
            if (32'(bank) == k) bank_wr[k][p] = 1'b1;
          end
        end else begin
          wr_bad = 1'b1;
        end
      end
    end
  end

  assign init_ok = 32'(init_addr) < ROWS;
  assign rd_ok   = 32'(rd_addr) < ROWS;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_addr <= 1'b0;
    else if (wr_bad || (init_en && !init_ok) || (rd_step && !rd_ok)) err_addr <= 1'b1;
  end

  for (genvar k = 0; k < BANKS; k++) begin : g_bank
    iob_except_ring_bank #(
      .DATA_WIDTH(DATA_WIDTH),
      .ROWS      (ROWS),
      .ROW_W     (ROW_W),
      .WPORTS    (WPORTS)
    ) u_bank (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (bank_wr[k]),
      .wr_row   (wr_row),
      .wr_data  (wr_data),
      .init_en  (init_en && init_ok),
      .init_row (init_addr),
      .init_data(init_data[k*DATA_WIDTH +: DATA_WIDTH]),
      .rd_step  (rd_step),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data[k*DATA_WIDTH +: DATA_WIDTH]),
      .rd_vld   (rd_vld[k])
    );
  end

  always_comb begin
    rd_any   = |rd_vld;
    rd_first = '0;
    for (int unsigned k = BANKS; k > 0; k--) begin
      if (rd_vld[k-1]) rd_first = BANK_W'(k-1);
    end
  end

endmodule

// File: tb/tb_iob_except_ring.sv
// Directed and randomised checks of iob_except_ring against a slot-array reference model.
module tb_iob_except_ring;
  import iob_except_ring_pkg::*;

  localparam int DW = EXCEPT_W;
  localparam int NR = 48;
  localparam int NB = 10;
  localparam int NP = 9;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     wr_en;
  logic [NP*10-1:0]  wr_addr;
  logic [NP*DW-1:0]  wr_data;
  logic              init_en;
  logic [5:0]        init_addr;
  logic [NB*DW-1:0]  init_data;
  logic              rd_step;
  logic [5:0]        rd_addr;
  logic [NB*DW-1:0]  rd_data;
  logic [NB-1:0]     rd_vld;
  logic              rd_any;
  logic [3:0]        rd_first;
  logic              err_addr;

  iob_except_ring dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .init_en(init_en), .init_addr(init_addr), .init_data(init_data),
    .rd_step(rd_step), .rd_addr(rd_addr), .rd_data(rd_data), .rd_vld(rd_vld),
    .rd_any(rd_any), .rd_first(rd_first), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] m_data [NR][NB];
  bit            m_vld  [NR][NB];
  int            m_cap;
  bit            m_err;
  int            compared = 0;
  int            mismatched = 0;

  task automatic chk(input string tag, input logic [NB*DW-1:0] obs, input logic [NB*DW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) for (int b = 0; b < NB; b++) m_vld[r][b] = 0;
    m_cap = 0;
    m_err = 0;
  endtask

  // Applies the inputs present at this clock edge to the slot model.
  task automatic model_edge();
    int row, bank;
    for (int p = 0; p < NP; p++) begin
      if (wr_en[p]) begin
        bank = int'(wr_addr[p*10 +: 4]);
        row  = int'(wr_addr[p*10+4 +: 6]);
        if (row < NR && bank < NB) begin
          m_data[row][bank] = wr_data[p*DW +: DW];
          m_vld[row][bank]  = 1;
        end else m_err = 1;
      end
    end
    if (init_en) begin
      if (int'(init_addr) < NR) begin
        for (int b = 0; b < NB; b++) begin
          m_data[init_addr][b] = init_data[b*DW +: DW];
          m_vld[init_addr][b]  = 0;
        end
      end else m_err = 1;
    end
    if (rd_step) begin
      m_cap = int'(rd_addr);
      if (m_cap >= NR) m_err = 1;
    end
  endtask

  task automatic check_all(input string tag);
    logic [NB*DW-1:0] ed;
    logic [NB-1:0]    ev;
    int               first;
    ed = '0;
    ev = '0;
    first = -1;
    if (m_cap < NR) begin
      for (int b = 0; b < NB; b++) begin
        if (m_vld[m_cap][b]) begin
          ev[b] = 1'b1;
          ed[b*DW +: DW] = m_data[m_cap][b];
          if (first < 0) first = b;
        end
      end
    end
    chk({tag, ".rd_data"},  rd_data, ed);
    chk({tag, ".rd_vld"},   NB*DW'(rd_vld), NB*DW'(ev));
    chk({tag, ".rd_any"},   NB*DW'(rd_any), NB*DW'(ev != '0));
    chk({tag, ".rd_first"}, NB*DW'(rd_first), NB*DW'((first < 0) ? 0 : first));
    chk({tag, ".err_addr"}, NB*DW'(err_addr), NB*DW'(m_err));
  endtask

  task automatic clear_inputs();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    init_en = 1'b0; init_addr = '0; init_data = '0;
    rd_step = 1'b0; rd_addr = '0;
  endtask

  task automatic set_wr(input int p, input int row, input int bank, input logic [DW-1:0] d);
    logic [5:0] r6;
    logic [3:0] b4;
    r6 = row[5:0];
    b4 = bank[3:0];
    wr_en[p] = 1'b1;
    wr_addr[p*10 +: 10] = {r6, b4};
    wr_data[p*DW +: DW] = d;
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
    clear_inputs();
  endtask

  task automatic random_phase(input int n, input bit allow_bad);
    for (int i = 0; i < n; i++) begin
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 3) == 0)
          set_wr(p, allow_bad ? $urandom_range(0, 63) : $urandom_range(0, 7),
                 allow_bad ? $urandom_range(0, 15) : $urandom_range(0, NB-1), DW'($urandom));
      end
      if ($urandom_range(0, 7) == 0) begin
        init_en = 1'b1;
        init_addr = 6'(allow_bad ? $urandom_range(0, 55) : $urandom_range(0, 7));
        for (int b = 0; b < NB; b++) init_data[b*DW +: DW] = DW'($urandom);
      end
      if ($urandom_range(0, 2) == 0) begin
        rd_step = 1'b1;
        rd_addr = 6'(allow_bad ? $urandom_range(0, 55) : $urandom_range(0, 7));
      end
      cycle(allow_bad ? "rand_bad" : "rand");
    end
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    check_all("reset");

    rd_step = 1'b1; rd_addr = 6'd5;
    cycle("rd_row5_empty");

    set_wr(2, 5, 7, 16'h1234);
    set_wr(4, 5, 3, 16'h0055);
    cycle("wr_row5");
    chk("row5.vld", NB*DW'(rd_vld), NB*DW'(10'b0010001000));
    chk("row5.first", NB*DW'(rd_first), NB*DW'(3));

    set_wr(0, 9, 1, 16'hAAAA);
    set_wr(8, 9, 1, 16'hBBBB);
    rd_step = 1'b1; rd_addr = 6'd9;
    cycle("collide");
    chk("collide.lane1", NB*DW'(rd_data[DW +: DW]), NB*DW'(16'hBBBB));

    init_en = 1'b1; init_addr = 6'd9;
    for (int b = 0; b < NB; b++) init_data[b*DW +: DW] = DW'(16'h1100 + b);
    set_wr(1, 9, 2, 16'h7777);
    cycle("init_vs_wr");
    chk("init.any", NB*DW'(rd_any), '0);

    random_phase(150, 1'b0);

    rd_step = 1'b1; rd_addr = 6'd5;
    cycle("cap_row5");
    set_wr(0, 5, 12, 16'hDEAD);
    cycle("bad_bank");
    chk("bad_bank.err", NB*DW'(err_addr), NB*DW'(1));
    rd_step = 1'b1; rd_addr = 6'd50;
    cycle("rd_bad_row");

    random_phase(150, 1'b1);
    chk("err_sticky", NB*DW'(err_addr), NB*DW'(1));

    set_wr(3, 4, 6, 16'h4242);
    rd_step = 1'b1; rd_addr = 6'd4;
    cycle("pre_async");
    chk("pre_async.any", NB*DW'(rd_any), NB*DW'(1));
    #2 rst = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b1;
    check_all("post_rst");
    cycle("post_rst_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
